// File: rtl/dct_8_stage_6_serialize.sv
// dct_8_stage_6_serialize
// Output stage of the 8-point DCT pipeline. Buffers one 512-bit vector of
// eight signed 64-bit coefficients and streams them out one per cycle in
// natural frequency order (word n comes from lane bitrev(n)) over a 64-bit
// valid/ready interface. This stage is the backpressure point for the
// always-ready stages upstream.
//
// Optional feature: define DCT_8_STAGE_6_ROUND_EN to apply a round-half-up
// arithmetic right shift by SHIFT to every emitted word.
module dct_8_stage_6_serialize #(
   parameter int SHIFT = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] i_data_in,
   input  logic         i_valid,
   output logic         i_ready,
   output logic [63:0]  o_data_out,
   output logic [2:0]   o_index,
   output logic         o_last,
   output logic         o_valid,
   input  logic         o_ready
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t       state_reg, state_next;
   logic [2:0]   cnt_reg, cnt_next;
   logic [511:0] buf_reg;
   logic         load;
   logic         acc;
   logic         xfer;

   logic [63:0]  lane [8];
   logic [2:0]   lane_sel;
   logic [63:0]  sel_word;

   // Out-of-range shift amounts have no meaning; this block only marks them.
   if (SHIFT < 0 || SHIFT > 16) begin : g_shift_out_of_range
   end

   // Split the buffered vector into its eight coefficient lanes.
   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane[gi] = buf_reg[64*gi +: 64];
   end

   // Handshakes. A new vector is taken only when the buffer is empty or the
   // final word is leaving this very cycle (zero-bubble reload).
   assign i_ready = !rst && ((state_reg == IDLE) ||
                             (cnt_reg == 3'd7 && o_ready));
   assign acc     = i_valid && i_ready;
   assign o_valid = (state_reg == EMIT);
   assign xfer    = o_valid && o_ready;
   assign o_last  = o_valid && (cnt_reg == 3'd7);
   assign o_index = cnt_reg;

   // Word n is drawn from lane bitrev(n); cnt stays 0 in IDLE so lane 0 shows.
   assign lane_sel = {cnt_reg[0], cnt_reg[1], cnt_reg[2]};
   assign sel_word = lane[lane_sel];

`ifdef DCT_8_STAGE_6_ROUND_EN
   // Half an LSB of the shifted result; zero when no shift is applied.
   localparam logic signed [64:0] RND = (SHIFT > 0) ? (65'sd1 <<< (SHIFT - 1)) : 65'sd0;
   logic signed [64:0] rnd_sum;

   // Sign-extend to 65 bits so the rounding add cannot overflow.
   assign rnd_sum    = $signed({sel_word[63], sel_word}) + RND;
   assign o_data_out = 64'(rnd_sum >>> SHIFT);
`else
   assign o_data_out = sel_word;
`endif

   // Next-state logic: load control, word counter and IDLE/EMIT sequencing.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (acc) begin
               load       = 1'b1;
               cnt_next   = 3'd0;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (xfer) begin
               if (cnt_reg != 3'd7) begin
                  cnt_next = cnt_reg + 3'd1;
               end else begin
                  cnt_next = 3'd0;
                  if (acc) begin
                     load = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 3'd0;
         end
      endcase
   end

   // State, counter and vector buffer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 3'd0;
         buf_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (load) begin
            buf_reg <= i_data_in;
         end
      end
   end

endmodule

// File: tb/tb_dct_8_stage_6_serialize.sv
// tb_dct_8_stage_6_serialize
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a word-queue reference model of the serializer.
module tb_dct_8_stage_6_serialize;

   localparam int SHIFT = 3;

   logic         clk;
   logic         rst;
   logic [511:0] i_data_in;
   logic         i_valid;
   logic         i_ready;
   logic [63:0]  o_data_out;
   logic [2:0]   o_index;
   logic         o_last;
   logic         o_valid;
   logic         o_ready;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [63:0] data;
      logic [2:0]  idx;
      logic        last;
   } word_t;

   word_t       exp_q[$];
   logic [63:0] idle_word;   // expected o_data_out while no vector is buffered
   int          order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   dct_8_stage_6_serialize #(.SHIFT(SHIFT)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_data_in  (i_data_in),
      .i_valid    (i_valid),
      .i_ready    (i_ready),
      .o_data_out (o_data_out),
      .o_index    (o_index),
      .o_last     (o_last),
      .o_valid    (o_valid),
      .o_ready    (o_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Final scaling of one coefficient as the output should present it.
   function automatic logic [63:0] scale(input logic [63:0] v);
`ifdef DCT_8_STAGE_6_ROUND_EN
      longint  x;
      longint  half;
      logic signed [64:0] s;
      x    = longint'(v);
      half = (SHIFT > 0) ? (longint'(1) <<< (SHIFT - 1)) : 0;
      s    = 65'(x) + 65'(half);
      s    = s >>> SHIFT;
      return s[63:0];
`else
      return v;
`endif
   endfunction

   function automatic logic [511:0] make_vec(input longint l0, input longint l1,
                                             input longint l2, input longint l3,
                                             input longint l4, input longint l5,
                                             input longint l6, input longint l7);
      return {64'(l7), 64'(l6), 64'(l5), 64'(l4), 64'(l3), 64'(l2), 64'(l1), 64'(l0)};
   endfunction

   // One clock cycle: drive inputs, check outputs against the model,
   // then advance the model across the rising edge.
   task automatic step(input logic r, input logic v, input logic [511:0] d, input logic ordy);
      logic  exp_ready;
      logic  exp_xfer;
      logic  exp_acc;
      word_t w;
      rst       = r;
      i_valid   = v;
      i_data_in = d;
      o_ready   = ordy;
      #1;
      exp_ready = !r && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
      exp_xfer  = (exp_q.size() > 0) && ordy;
      exp_acc   = v && exp_ready;
      check("i_ready", 64'(i_ready), 64'(exp_ready));
      check("o_valid", 64'(o_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         check("o_data_out", o_data_out, exp_q[0].data);
         check("o_index", 64'(o_index), 64'(exp_q[0].idx));
         check("o_last", 64'(o_last), 64'(exp_q[0].last));
      end else begin
         check("idle_data", o_data_out, idle_word);
         check("idle_index", 64'(o_index), 64'd0);
         check("idle_last", 64'(o_last), 64'd0);
      end
      @(posedge clk);
      if (r) begin
         exp_q.delete();
         idle_word = scale(64'd0);
      end else begin
         if (exp_xfer) begin
            if (exp_q[0].last) $display("vector done: last word %0h", exp_q[0].data);
            void'(exp_q.pop_front());
         end
         if (exp_acc) begin
            $display("vector accepted: lane0 %0h", d[63:0]);
            for (int n = 0; n < 8; n++) begin
               w.data = scale(d[64*order[n] +: 64]);
               w.idx  = 3'(n);
               w.last = (n == 7);
               exp_q.push_back(w);
            end
            idle_word = scale(d[63:0]);
         end
      end
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
   endtask

   logic [511:0] vec_a;
   logic [511:0] vec_b;

   initial begin
      rst       = 1'b1;
      i_valid   = 1'b1;
      i_data_in = '0;
      o_ready   = 1'b1;
      idle_word = '0;
      @(posedge clk);
      #1;
      idle_word = scale(64'd0);

      // Reset held with valid asserted: nothing accepted.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, {8{64'h5555}}, 1'b1);

      // Ordering: lanes 100+k.
      vec_a = make_vec(100, 101, 102, 103, 104, 105, 106, 107);
      step(1'b0, 1'b1, vec_a, 1'b1);
      idle_cycles(9);

      // Back-to-back with valid held.
      vec_a = make_vec(0, 1, 2, 3, 4, 5, 6, 7);
      vec_b = make_vec(16, 17, 18, 19, 20, 21, 22, 23);
      step(1'b0, 1'b1, vec_a, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, vec_b, 1'b1);
      idle_cycles(9);

      // Backpressure at cnt=3 for 4 cycles, valid offered meanwhile.
      vec_a = make_vec(200, 201, 202, 203, 204, 205, 206, 207);
      step(1'b0, 1'b1, vec_a, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, vec_b, 1'b0);
      idle_cycles(6);

      // Reset in the middle of emission, then a fresh vector.
      step(1'b0, 1'b1, vec_a, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, vec_b, 1'b1);
      idle_cycles(9);

      // Rounding pattern (raw lanes without the rounding build).
      vec_a = make_vec(12, -12, 4, -4, 7, 8, -5, 0);
      step(1'b0, 1'b1, vec_a, 1'b1);
      idle_cycles(9);

      // Negative and extreme values.
      vec_a = make_vec(-1, 64'sh7FFF_FFFF_FFFF_FFFF, -8, -9, 3, -3, 64'sh8000_0000_0000_0000, 11);
      step(1'b0, 1'b1, vec_a, 1'b1);
      idle_cycles(9);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         logic [511:0] d;
         for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), d,
              ($urandom_range(0, 3) != 0));
      end
      idle_cycles(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete, %0d checks", n_checks);
      $fatal(1, "timeout");
   end

endmodule
